// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: receiver state encodings, default bit timing and the
// status-register bit positions used by the peripheral register map and uart_tx.
package uart_defs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   localparam int UART_CLKS_PER_BIT_DEF = 512;

   localparam int UART_STAT_VALID     = 0;
   localparam int UART_STAT_FRAME_ERR = 1;
   localparam int UART_STAT_OVERRUN   = 2;
   localparam int UART_STAT_BUSY      = 3;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level (1).
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: start-bit validation at half-bit, mid-bit data sampling LSB first,
// stop-bit check, and a 1-deep holding buffer with sticky frame-error/overrun flags.
module uart_rx_unit
   import uart_defs_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
   parameter int CNT_W        = 10
) (
   input  logic       sysclk,
   input  logic       Reset,
   input  logic       UART_IN,
   input  logic       rd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_t      state_q, state_d;
   logic             rxs;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   logic cnt_clr, bit_clr, shift_en, done_ok, done_bad;

   uart_sync2 u_sync (
      .clk (sysclk),
      .rst (Reset),
      .d   (UART_IN),
      .q   (rxs)
   );

   always_ff @(posedge sysclk or posedge Reset) begin
      if (Reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      cnt_clr  = 1'b0;
      bit_clr  = 1'b0;
      shift_en = 1'b0;
      done_ok  = 1'b0;
      done_bad = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rxs) begin
               state_d = ST_START;
               cnt_clr = 1'b1;
            end
         end
         ST_START: begin
            // Line back high at half-bit means the falling edge was a glitch.
            if (cnt == HALF_M1) begin
               cnt_clr = 1'b1;
               if (rxs) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
                  bit_clr = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (cnt == FULL_M1) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt == FULL_M1) begin
               cnt_clr  = 1'b1;
               state_d  = ST_IDLE;
               done_ok  = rxs;
               done_bad = !rxs;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge Reset) begin
      if (Reset) begin
         cnt     <= '0;
         bit_idx <= '0;
      end else begin
         if (cnt_clr || state_q == ST_IDLE) cnt <= '0;
         else                               cnt <= cnt + CNT_W'(1);
         if (bit_clr)       bit_idx <= '0;
         else if (shift_en) bit_idx <= bit_idx + 3'd1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (shift_en) shift[bit_idx] <= rxs;
   end

   // Later assignments win: a completing byte overrides a coincident rd clear.
   always_ff @(posedge sysclk or posedge Reset) begin
      if (Reset) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (rd) begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
         if (done_ok) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            if (rx_valid && !rd) overrun <= 1'b1;
         end
         if (done_bad) frame_err <= 1'b1;
      end
   end

   assign rx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_unit.sv
// Bench for uart_rx_unit: table of back-to-back frames checked through a scoreboard,
// plus hand-written glitch, mid-frame reset and rd-at-completion sequences.
module tb_uart_rx_unit;

   localparam int CPB = 512;
   localparam int DONE_DLY = 2 + CPB / 2 + 9 * CPB;

   logic       sysclk = 1'b0;
   logic       Reset;
   logic       UART_IN;
   logic       rd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   uart_rx_unit #(.CLKS_PER_BIT(CPB), .CNT_W(10)) dut (
      .sysclk    (sysclk),
      .Reset     (Reset),
      .UART_IN   (UART_IN),
      .rd        (rd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_busy   (rx_busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #3 sysclk = ~sysclk;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic       ferr;
      logic       ovr;
   } exp_t;

   typedef struct {
      logic [7:0] byte_v;
      logic       stop;
      logic       rd_before;
      exp_t       exp;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[6];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   bl;
   int   glitch_len;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_sb(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got 0x%0h, expected an entry", name, rx_data);
      end else begin
         e = sb_q.pop_front();
         chk({name, " rx_data"},   rx_data,   e.data);
         chk({name, " rx_valid"},  rx_valid,  e.valid);
         chk({name, " frame_err"}, frame_err, e.ferr);
         chk({name, " overrun"},   overrun,   e.ovr);
      end
   endtask

   // Drives one frame starting at the current negedge; counts cycles where rx_busy
   // was low inside the start/data bits.
   task automatic send_frame(input logic [7:0] b, input logic stop, output int busy_low);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      busy_low = 0;
      for (int i = 0; i < 10; i++) begin
         UART_IN = f[i];
         for (int c = 0; c < CPB; c++) begin
            @(negedge sysclk);
            if (i < 9 && (i > 0 || c >= 4) && !rx_busy) busy_low++;
         end
      end
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      @(negedge sysclk);
      rd = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h01, 1'b1, 1'b0, '{8'h01, 1'b1, 1'b0, 1'b0}};
      vecs[1] = '{8'hFF, 1'b1, 1'b0, '{8'hFF, 1'b1, 1'b0, 1'b1}};
      vecs[2] = '{8'h5A, 1'b1, 1'b1, '{8'h5A, 1'b1, 1'b0, 1'b0}};
      vecs[3] = '{8'h81, 1'b1, 1'b1, '{8'h81, 1'b1, 1'b0, 1'b0}};
      vecs[4] = '{8'hA5, 1'b0, 1'b1, '{8'h81, 1'b0, 1'b1, 1'b0}};
      vecs[5] = '{8'h7E, 1'b1, 1'b0, '{8'h7E, 1'b1, 1'b1, 1'b0}};

      Reset   = 1'b1;
      rd      = 1'b0;
      UART_IN = 1'b1;
      repeat (5) @(negedge sysclk);
      chk("reset rx_data",   rx_data,   0);
      chk("reset rx_valid",  rx_valid,  0);
      chk("reset rx_busy",   rx_busy,   0);
      chk("reset frame_err", frame_err, 0);
      chk("reset overrun",   overrun,   0);
      Reset = 1'b0;
      repeat (20) @(negedge sysclk);
      chk("idle rx_busy", rx_busy, 0);

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].rd_before) pulse_rd();
         sb_q.push_back(vecs[i].exp);
         send_frame(vecs[i].byte_v, vecs[i].stop, bl);
         chk($sformatf("vec%0d busy gaps", i), bl, 0);
         check_sb($sformatf("vec%0d", i));
      end

      // Short low glitch: must be rejected at half-bit without touching the buffer.
      UART_IN = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge sysclk);
         if (c == 100) chk("glitch busy", rx_busy, 1);
      end
      UART_IN = 1'b1;
      glitch_len = 200;
      while (rx_busy && glitch_len < 600) begin
         @(negedge sysclk);
         glitch_len++;
      end
      chk("glitch busy release window", (glitch_len >= 255 && glitch_len <= 265), 1);
      chk("glitch rx_valid",  rx_valid,  1);
      chk("glitch frame_err", frame_err, 1);
      chk("glitch rx_data",   rx_data,   8'h7E);
      chk("glitch overrun",   overrun,   0);
      repeat (20) @(negedge sysclk);

      // Asynchronous reset in the middle of data bit 4.
      fork
         send_frame(8'hE7, 1'b1, bl);
         begin
            repeat (CPB * 5 + CPB / 2) @(negedge sysclk);
            chk("midreset busy before", rx_busy, 1);
            #1 Reset = 1'b1;
            #1;
            chk("midreset rx_data",   rx_data,   0);
            chk("midreset rx_valid",  rx_valid,  0);
            chk("midreset rx_busy",   rx_busy,   0);
            chk("midreset frame_err", frame_err, 0);
            chk("midreset overrun",   overrun,   0);
         end
      join
      @(negedge sysclk);
      Reset = 1'b0;
      repeat (20) @(negedge sysclk);
      sb_q.push_back('{8'h3C, 1'b1, 1'b0, 1'b0});
      send_frame(8'h3C, 1'b1, bl);
      check_sb("post-reset 3C");

      // rd lands on the exact completion cycle while the previous byte is unread.
      sb_q.push_back('{8'hC3, 1'b1, 1'b0, 1'b0});
      fork
         send_frame(8'hC3, 1'b1, bl);
         begin
            repeat (DONE_DLY) @(negedge sysclk);
            rd = 1'b1;
            @(negedge sysclk);
            rd = 1'b0;
         end
      join
      check_sb("rd at completion");

      pulse_rd();
      chk("final rd rx_valid",  rx_valid,  0);
      chk("final rd frame_err", frame_err, 0);
      chk("final rd overrun",   overrun,   0);
      chk("final rd rx_data",   rx_data,   8'hC3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
